instruction_fetcher: RTL and testbench

Front-end fetch unit of the out-of-order RV32I core. It sits between the ICache and the Dispatcher, and it is the consumer of the RoB's fetcher-side outputs: branch resolution, JALR target and mispredict redirect. It holds the PC and predicts conditional branches with a 2-bit BHT. It stalls on JALR until the RoB returns the target, and it redirects and flushes on misprediction.

---
 rtl/instruction_fetcher_pkg.sv | 24 ++
 rtl/instruction_fetcher_branch_history_table.sv | 51 +++++
 rtl/instruction_fetcher.sv | 168 ++++++++++++++++
 tb/tb_instruction_fetcher.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetcher_pkg.sv
// Shared definitions for the fetch unit: RV32I opcodes, immediate decoders
// and the fetch FSM state encoding.
package instruction_fetcher_pkg;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_WAIT_IC,
    ST_HOLD,
    ST_WAIT_JALR
  } fetch_state_e;

  function automatic logic [31:0] j_imm(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] b_imm(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/instruction_fetcher_branch_history_table.sv
// 2-bit saturating-counter branch predictor. With IF_BHT_EN defined the counters
// are live; otherwise prediction is static backward-taken/forward-not-taken.
module branch_history_table #(
  parameter int ADDR_WIDTH = 32,
  parameter int BHT_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [ADDR_WIDTH-1:0] rd_pc_i,
  input  logic                  static_hint_i,
  output logic                  predict_o,
  input  logic                  upd_en_i,
  input  logic                  upd_taken_i,
  input  logic [ADDR_WIDTH-1:0] upd_pc_i
);

`ifdef IF_BHT_EN
  localparam int         ENTRIES  = 1 << BHT_WIDTH;
  localparam logic [1:0] CNT_INIT = 2'b01;

  logic [1:0]           cnt_q [ENTRIES];
  logic [BHT_WIDTH-1:0] rd_idx;
  logic [BHT_WIDTH-1:0] upd_idx;
  logic                 unused_ok;

  assign rd_idx    = rd_pc_i[BHT_WIDTH+1:2];
  assign upd_idx   = upd_pc_i[BHT_WIDTH+1:2];
  assign predict_o = cnt_q[rd_idx][1];
  assign unused_ok = ^{static_hint_i, rd_pc_i, upd_pc_i};

  // NOTE: the counters are flops, not RAM, so every entry takes the weak
  // not-taken value on reset; an unreset array would predict garbage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_INIT;
    end else if (en_i && upd_en_i) begin
      if (upd_taken_i && cnt_q[upd_idx] != 2'b11)
        cnt_q[upd_idx] <= cnt_q[upd_idx] + 2'b01;
      else if (!upd_taken_i && cnt_q[upd_idx] != 2'b00)
        cnt_q[upd_idx] <= cnt_q[upd_idx] - 2'b01;
    end
  end
`else
  logic unused_ok;

  assign predict_o = static_hint_i;
  assign unused_ok = ^{clk_i, rst_i, en_i, rd_pc_i, upd_en_i, upd_taken_i, upd_pc_i};
`endif

endmodule

// File: rtl/instruction_fetcher.sv
// RV32I fetch unit: PC, ICache request/response, branch prediction, JALR stall and
// mispredict redirect. Define IF_BHT_EN for dynamic (BHT) prediction.
module instruction_fetcher
  import instruction_fetcher_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    BHT_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  Sys_clk,
  input  logic                  Sys_rst,
  input  logic                  Sys_rdy,
  output logic                  IFIC_en,
  output logic [ADDR_WIDTH-1:0] IFIC_addr,
  input  logic                  ICIF_en,
  input  logic [31:0]           ICIF_data,
  input  logic                  DPIF_full,
  output logic                  IFDP_en,
  output logic [31:0]           IFDP_inst,
  output logic [ADDR_WIDTH-1:0] IFDP_pc,
  output logic                  IFDP_predict_result,
  input  logic                  RoBIF_jalr_en,
  input  logic                  RoBIF_branch_en,
  input  logic                  RoBIF_pre_judge,
  input  logic                  RoBIF_branch_result,
  input  logic [ADDR_WIDTH-1:0] RoBIF_branch_pc,
  input  logic [ADDR_WIDTH-1:0] RoBIF_next_pc
);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  ific_en_q, ific_en_d;
  logic [ADDR_WIDTH-1:0] ific_addr_q, ific_addr_d;
  logic                  ifdp_en_q, ifdp_en_d;
  logic [31:0]           ifdp_inst_q, ifdp_inst_d;
  logic [ADDR_WIDTH-1:0] ifdp_pc_q, ifdp_pc_d;
  logic                  ifdp_pred_q, ifdp_pred_d;
  logic                  hold_jalr_q, hold_jalr_d;

  logic                  mispredict;
  logic                  is_jal, is_jalr, is_branch;
  logic                  bht_pred;
  logic                  predict;
  logic [ADDR_WIDTH-1:0] fetch_next_pc;

  assign mispredict = RoBIF_branch_en && !RoBIF_pre_judge;
  assign is_jal     = ICIF_data[6:0] == OPC_JAL;
  assign is_jalr    = ICIF_data[6:0] == OPC_JALR;
  assign is_branch  = ICIF_data[6:0] == OPC_BRANCH;
  assign predict    = is_branch && bht_pred;

  branch_history_table #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .BHT_WIDTH (BHT_WIDTH)
  ) u_bht (
    .clk_i        (Sys_clk),
    .rst_i        (Sys_rst),
    .en_i         (Sys_rdy),
    .rd_pc_i      (pc_q),
    .static_hint_i(ICIF_data[31]),
    .predict_o    (bht_pred),
    .upd_en_i     (RoBIF_branch_en),
    .upd_taken_i  (RoBIF_branch_result),
    .upd_pc_i     (RoBIF_branch_pc)
  );

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    fetch_next_pc = pc_q + ADDR_WIDTH'(4);
    if (is_jal)
      fetch_next_pc = pc_q + ADDR_WIDTH'(signed'(j_imm(ICIF_data)));
    else if (predict)
      fetch_next_pc = pc_q + ADDR_WIDTH'(signed'(b_imm(ICIF_data)));
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample
  // the same pre-edge values regardless of process ordering.
  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst)      state_q <= ST_FETCH;
    else if (Sys_rdy) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (mispredict) begin
      state_d = ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH:     if (!DPIF_full) state_d = ST_WAIT_IC;
        ST_WAIT_IC:
          if (ICIF_en) begin
            if (DPIF_full)    state_d = ST_HOLD;
            else if (is_jalr) state_d = ST_WAIT_JALR;
            else              state_d = ST_FETCH;
          end
        ST_HOLD:      if (!DPIF_full) state_d = hold_jalr_q ? ST_WAIT_JALR : ST_FETCH;
        ST_WAIT_JALR: if (RoBIF_jalr_en) state_d = ST_FETCH;
        default:      state_d = ST_FETCH;
      endcase
    end
  end

  // A pending instruction stays valid until a cycle with DPIF_full low takes it.
  always_comb begin
    pc_d        = pc_q;
    ific_en_d   = ific_en_q;
    ific_addr_d = ific_addr_q;
    ifdp_en_d   = ifdp_en_q && DPIF_full;
    ifdp_inst_d = ifdp_inst_q;
    ifdp_pc_d   = ifdp_pc_q;
    ifdp_pred_d = ifdp_pred_q;
    hold_jalr_d = hold_jalr_q;
    if (mispredict) begin
      pc_d      = RoBIF_next_pc;
      ific_en_d = 1'b0;
      ifdp_en_d = 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          ific_en_d = !DPIF_full;
          if (!DPIF_full) ific_addr_d = pc_q;
        end
        ST_WAIT_IC:
          if (ICIF_en) begin
            ific_en_d   = 1'b0;
            ifdp_en_d   = 1'b1;
            ifdp_inst_d = ICIF_data;
            ifdp_pc_d   = pc_q;
            ifdp_pred_d = predict;
            pc_d        = fetch_next_pc;
            hold_jalr_d = is_jalr;
          end
        ST_WAIT_JALR: if (RoBIF_jalr_en) pc_d = RoBIF_next_pc;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      pc_q        <= RESET_PC;
      ific_en_q   <= 1'b0;
      ific_addr_q <= '0;
      ifdp_en_q   <= 1'b0;
      ifdp_inst_q <= '0;
      ifdp_pc_q   <= '0;
      ifdp_pred_q <= 1'b0;
      hold_jalr_q <= 1'b0;
    end else if (Sys_rdy) begin
      pc_q        <= pc_d;
      ific_en_q   <= ific_en_d;
      ific_addr_q <= ific_addr_d;
      ifdp_en_q   <= ifdp_en_d;
      ifdp_inst_q <= ifdp_inst_d;
      ifdp_pc_q   <= ifdp_pc_d;
      ifdp_pred_q <= ifdp_pred_d;
      hold_jalr_q <= hold_jalr_d;
    end
  end

  assign IFIC_en             = ific_en_q;
  assign IFIC_addr           = ific_addr_q;
  assign IFDP_en             = ifdp_en_q;
  assign IFDP_inst           = ifdp_inst_q;
  assign IFDP_pc             = ifdp_pc_q;
  assign IFDP_predict_result = ifdp_pred_q;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed self-checking bench for instruction_fetcher; expectations follow the
// IF_BHT_EN setting of the build.
module tb_instruction_fetcher;

  localparam logic [31:0] I_ADDI     = 32'h00100093;  // addi x1,x0,1
  localparam logic [31:0] I_JAL      = 32'h1000006F;  // jal  x0,+0x100
  localparam logic [31:0] I_JALR     = 32'h00008067;  // jalr x0,0(x1)
  localparam logic [31:0] I_BEQ_FWD  = 32'h02000063;  // beq  x0,x0,+0x20
  localparam logic [31:0] I_BEQ_BWD  = 32'hFE000CE3;  // beq  x0,x0,-8

  logic        Sys_clk = 1'b0;
  logic        Sys_rst, Sys_rdy;
  logic        IFIC_en;
  logic [31:0] IFIC_addr;
  logic        ICIF_en;
  logic [31:0] ICIF_data;
  logic        DPIF_full;
  logic        IFDP_en;
  logic [31:0] IFDP_inst;
  logic [31:0] IFDP_pc;
  logic        IFDP_predict_result;
  logic        RoBIF_jalr_en, RoBIF_branch_en, RoBIF_pre_judge, RoBIF_branch_result;
  logic [31:0] RoBIF_branch_pc, RoBIF_next_pc;

  int checks   = 0;
  int failures = 0;

  logic        exp_pred;
  logic [31:0] cur;

  always #5 Sys_clk = ~Sys_clk;

  instruction_fetcher dut (
    .Sys_clk            (Sys_clk),
    .Sys_rst            (Sys_rst),
    .Sys_rdy            (Sys_rdy),
    .IFIC_en            (IFIC_en),
    .IFIC_addr          (IFIC_addr),
    .ICIF_en            (ICIF_en),
    .ICIF_data          (ICIF_data),
    .DPIF_full          (DPIF_full),
    .IFDP_en            (IFDP_en),
    .IFDP_inst          (IFDP_inst),
    .IFDP_pc            (IFDP_pc),
    .IFDP_predict_result(IFDP_predict_result),
    .RoBIF_jalr_en      (RoBIF_jalr_en),
    .RoBIF_branch_en    (RoBIF_branch_en),
    .RoBIF_pre_judge    (RoBIF_pre_judge),
    .RoBIF_branch_result(RoBIF_branch_result),
    .RoBIF_branch_pc    (RoBIF_branch_pc),
    .RoBIF_next_pc      (RoBIF_next_pc)
  );

  task automatic step();
    @(posedge Sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ific_en"},   {31'b0, IFIC_en}, 32'h0);
    check({tag, "_ific_addr"}, IFIC_addr, 32'h0);
    check({tag, "_ifdp_en"},   {31'b0, IFDP_en}, 32'h0);
    check({tag, "_ifdp_inst"}, IFDP_inst, 32'h0);
    check({tag, "_ifdp_pc"},   IFDP_pc, 32'h0);
    check({tag, "_ifdp_pred"}, {31'b0, IFDP_predict_result}, 32'h0);
  endtask

  task automatic check_ifdp(input string tag, input logic [31:0] pc,
                            input logic [31:0] inst, input logic pred);
    check({tag, "_en"},   {31'b0, IFDP_en}, 32'h1);
    check({tag, "_pc"},   IFDP_pc, pc);
    check({tag, "_inst"}, IFDP_inst, inst);
    check({tag, "_pred"}, {31'b0, IFDP_predict_result}, {31'b0, pred});
  endtask

  // Bounded wait for the next fetch request, then check its address.
  task automatic wait_fetch(input string tag, input logic [31:0] addr);
    int n = 0;
    while (IFIC_en !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check({tag, "_ific_en"},   {31'b0, IFIC_en}, 32'h1);
    check({tag, "_ific_addr"}, IFIC_addr, addr);
  endtask

  task automatic serve(input logic [31:0] inst, input logic full);
    ICIF_en   = 1'b1;
    ICIF_data = inst;
    DPIF_full = full;
    step();
    ICIF_en   = 1'b0;
    ICIF_data = '0;
  endtask

  task automatic mispredict(input logic [31:0] bpc, input logic taken, input logic [31:0] npc);
    RoBIF_branch_en     = 1'b1;
    RoBIF_pre_judge     = 1'b0;
    RoBIF_branch_result = taken;
    RoBIF_branch_pc     = bpc;
    RoBIF_next_pc       = npc;
    step();
    RoBIF_branch_en     = 1'b0;
    RoBIF_pre_judge     = 1'b1;
  endtask

  initial begin
    Sys_rst = 1'b1; Sys_rdy = 1'b1; ICIF_en = 1'b0; ICIF_data = '0; DPIF_full = 1'b0;
    RoBIF_jalr_en = 1'b0; RoBIF_branch_en = 1'b0; RoBIF_pre_judge = 1'b1;
    RoBIF_branch_result = 1'b0; RoBIF_branch_pc = '0; RoBIF_next_pc = '0;
    #12;
    check_zero("reset");
    step();
    Sys_rst = 1'b0;

    // Global enable low freezes the FSM in FETCH.
    Sys_rdy = 1'b0;
    step();
    step();
    check("rdy_hold", {31'b0, IFIC_en}, 32'h0);
    Sys_rdy = 1'b1;

    // Sequential fetch with one-cycle delivery.
    wait_fetch("f0", 32'h0);
    serve(I_ADDI, 1'b0);
    check_ifdp("addi", 32'h0, I_ADDI, 1'b0);
    check("addi_ific_drop", {31'b0, IFIC_en}, 32'h0);
    wait_fetch("f4", 32'h4);
    check("addi_single", {31'b0, IFDP_en}, 32'h0);
    serve(I_ADDI, 1'b0);
    wait_fetch("f8", 32'h8);

    // JAL redirects without prediction.
    serve(I_JAL, 1'b0);
    check_ifdp("jal", 32'h8, I_JAL, 1'b0);
    wait_fetch("jal_tgt", 32'h108);

    // JALR stalls until the RoB supplies the target.
    serve(I_JALR, 1'b0);
    check_ifdp("jalr", 32'h108, I_JALR, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("jalr_stall", {31'b0, IFIC_en}, 32'h0);
    end
    RoBIF_jalr_en = 1'b1;
    RoBIF_next_pc = 32'h400;
    step();
    RoBIF_jalr_en = 1'b0;
    wait_fetch("jalr_tgt", 32'h400);

    // A JALR target outside WAIT_JALR is ignored.
    RoBIF_jalr_en = 1'b1;
    RoBIF_next_pc = 32'h999;
    step();
    RoBIF_jalr_en = 1'b0;
    check("jalr_ignored_en",   {31'b0, IFIC_en}, 32'h1);
    check("jalr_ignored_addr", IFIC_addr, 32'h400);

    // Mispredict in WAIT_IC discards a same-cycle ICache response.
    ICIF_en   = 1'b1;
    ICIF_data = I_ADDI;
    mispredict(32'h200, 1'b1, 32'h80);
    ICIF_en   = 1'b0;
    ICIF_data = '0;
    check("flush_ifdp_en", {31'b0, IFDP_en}, 32'h0);
    check("flush_ific_en", {31'b0, IFIC_en}, 32'h0);
    wait_fetch("redirect", 32'h80);
    check("flush_no_late", {31'b0, IFDP_en}, 32'h0);

    mispredict(32'h300, 1'b0, 32'h40);
    wait_fetch("to40", 32'h40);

    // First branch fetch coincides with a taken update at its own index:
    // the lookup sees the old weak-not-taken counter.
    RoBIF_branch_en     = 1'b1;
    RoBIF_pre_judge     = 1'b1;
    RoBIF_branch_result = 1'b1;
    RoBIF_branch_pc     = 32'h40;
    serve(I_BEQ_FWD, 1'b0);
    RoBIF_branch_en     = 1'b0;
    check_ifdp("beq_first", 32'h40, I_BEQ_FWD, 1'b0);
    wait_fetch("beq_first_next", 32'h44);

    // Second taken update (via mispredict back to 0x40) saturates the counter.
    mispredict(32'h40, 1'b1, 32'h40);
    wait_fetch("refetch40", 32'h40);
    serve(I_BEQ_FWD, 1'b0);
`ifdef IF_BHT_EN
    exp_pred = 1'b1;
    cur      = 32'h60;
`else
    exp_pred = 1'b0;
    cur      = 32'h44;
`endif
    check_ifdp("beq_trained", 32'h40, I_BEQ_FWD, exp_pred);
    wait_fetch("beq_trained_next", cur);

    // Backward branch at an untouched index.
    serve(I_BEQ_BWD, 1'b0);
`ifdef IF_BHT_EN
    check_ifdp("beq_bwd", cur, I_BEQ_BWD, 1'b0);
    cur = cur + 32'h4;
`else
    check_ifdp("beq_bwd", cur, I_BEQ_BWD, 1'b1);
    cur = cur - 32'h8;
`endif
    wait_fetch("beq_bwd_next", cur);

    // Dispatcher full for three cycles starting at delivery.
    serve(I_ADDI, 1'b1);
    check_ifdp("hold0", cur, I_ADDI, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      check_ifdp("hold", cur, I_ADDI, 1'b0);
      check("hold_no_fetch", {31'b0, IFIC_en}, 32'h0);
    end
    DPIF_full = 1'b0;
    step();
    check("hold_single", {31'b0, IFDP_en}, 32'h0);
    cur = cur + 32'h4;
    wait_fetch("after_hold", cur);

    // Asynchronous reset in the middle of HOLD.
    serve(I_ADDI, 1'b1);
    step();
    check("pre_rst_hold", {31'b0, IFDP_en}, 32'h1);
    Sys_rst = 1'b1;
    #1;
    check_zero("rst_mid_hold");
    DPIF_full = 1'b0;
    step();
    Sys_rst = 1'b0;
    wait_fetch("post_rst", 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
